txword_fifo: RTL and testbench

- Synchronous word FIFO between the change detector and the serial word transmitter.
- Buffers every 32-bit word the detector strobes out while the transmitter is busy, so bursts of counter changes are not lost.
- Storage is an inferred block RAM plus one output holding register; the read side presents the stb/busy handshake that the word transmitter already consumes.

---
 rtl/txword_fifo_sdpram.sv | 36 +++
 rtl/txword_fifo.sv | 108 ++++++++++
 tb/tb_txword_fifo.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/txword_fifo_sdpram.sv
// Simple dual-port RAM: one write port, one registered read port, DW x 2^AW.
// Latency: read data appears one cycle after i_rd_en; write visible next cycle.
// Backpressure: none; the caller guarantees it never reads an address written the same cycle.
// Ports: i_clk; write port i_wr_en/i_wr_addr/i_wr_data; read port i_rd_en/i_rd_addr -> o_rd_data.
module txword_fifo_sdpram #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          i_clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rd_data_q;

  // No reset on storage or read register so the tools map this onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rd_en) begin
      rd_data_q <= mem_q[i_rd_addr];
    end
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: rtl/txword_fifo.sv
// Word FIFO between the change detector and the serial word transmitter.
// Latency: a write into an empty FIFO shows on o_stb/o_data after one edge.
// Backpressure: head word held stable while i_busy; writes while full and not popping are dropped (sticky o_overflow).
// Ports: i_clk, i_reset_n (async low); write side i_wr/i_data/o_full/o_fill/o_overflow;
//        read side o_stb/o_data/i_busy (word consumed when o_stb && !i_busy).
module txword_fifo #(
  parameter int DW     = 32,
  parameter int LGFLEN = 4
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_wr,
  input  logic [DW-1:0]   i_data,
  output logic            o_full,
  output logic [LGFLEN:0] o_fill,
  output logic            o_overflow,
  output logic            o_stb,
  output logic [DW-1:0]   o_data,
  input  logic            i_busy
);

  localparam int FW = LGFLEN + 1;
  localparam logic [FW-1:0] DEPTH = FW'(1) << LGFLEN;

  logic [LGFLEN-1:0] wr_ptr_q, wr_ptr_d;
  logic [LGFLEN-1:0] rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic              full_q;
  logic              overflow_q;
  logic [DW-1:0]     byp_q;
  logic              sel_byp_q;  // output word comes from bypass register, else from RAM read register
  logic [DW-1:0]     ram_rd_data;

  logic              stb;
  logic              pop;
  logic              push;
  logic              out_free;
  logic [FW-1:0]     ram_cnt;
  logic              load_ram;
  logic              bypass;
  logic              ram_wr;

  assign stb      = (fill_q != '0);
  assign pop      = stb && !i_busy;
  assign push     = i_wr && (!full_q || pop);
  assign out_free = !stb || pop;
  // Words sitting in RAM, excluding the one presented at the output.
  assign ram_cnt  = fill_q - FW'(stb);
  // The RAM read register itself is the output stage: reading mem[rd_ptr] on the
  // same edge the head is popped gives the next word one cycle later, no bubble.
  // The entry at rd_ptr was written on an earlier edge whenever ram_cnt != 0,
  // so there is never a read/write collision on one address.
  assign load_ram = out_free && (ram_cnt != '0);
  assign bypass   = out_free && (ram_cnt == '0) && push;
  assign ram_wr   = push && !bypass;

  always_comb begin
    wr_ptr_d = wr_ptr_q + LGFLEN'(ram_wr);
    rd_ptr_d = rd_ptr_q + LGFLEN'(load_ram);
    fill_d   = fill_q + FW'(push) - FW'(pop);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      byp_q      <= '0;
      sel_byp_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      full_q   <= (fill_d == DEPTH);
      if (i_wr && full_q && !pop) begin
        overflow_q <= 1'b1;
      end
      if (bypass) begin
        byp_q     <= i_data;
        sel_byp_q <= 1'b1;
      end else if (load_ram) begin
        sel_byp_q <= 1'b0;
      end
    end
  end

  txword_fifo_sdpram #(
    .DW (DW),
    .AW (LGFLEN)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (ram_wr),
    .i_wr_addr (wr_ptr_q),
    .i_wr_data (i_data),
    .i_rd_en   (load_ram),
    .i_rd_addr (rd_ptr_q),
    .o_rd_data (ram_rd_data)
  );

  assign o_full     = full_q;
  assign o_fill     = fill_q;
  assign o_overflow = overflow_q;
  assign o_stb      = stb;
  assign o_data     = sel_byp_q ? byp_q : ram_rd_data;

endmodule

// File: tb/tb_txword_fifo.sv
module tb_txword_fifo;

  localparam int DW     = 32;
  localparam int LGFLEN = 4;

  logic            i_clk;
  logic            i_reset_n;
  logic            i_wr;
  logic [DW-1:0]   i_data;
  logic            o_full;
  logic [LGFLEN:0] o_fill;
  logic            o_overflow;
  logic            o_stb;
  logic [DW-1:0]   o_data;
  logic            i_busy;

  int checks;
  int errors;

  txword_fifo #(
    .DW     (DW),
    .LGFLEN (LGFLEN)
  ) dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_wr       (i_wr),
    .i_data     (i_data),
    .o_full     (o_full),
    .o_fill     (o_fill),
    .o_overflow (o_overflow),
    .o_stb      (o_stb),
    .o_data     (o_data),
    .i_busy     (i_busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] drain_exp[16];
  logic [DW-1:0] head;
  int            sent;
  int            cyc;

  initial begin
    checks    = 0;
    errors    = 0;
    i_reset_n = 1'b0;
    i_wr      = 1'b0;
    i_data    = '0;
    i_busy    = 1'b0;
    #23;
    // Reset state
    check_eq("rst_stb",  64'(o_stb), 64'd0);
    check_eq("rst_fill", 64'(o_fill), 64'd0);
    check_eq("rst_data", 64'(o_data), 64'd0);
    check_eq("rst_full", 64'(o_full), 64'd0);
    check_eq("rst_ovf",  64'(o_overflow), 64'd0);
    i_reset_n = 1'b1;
    tick();

    // Single word with transmitter idle
    i_wr = 1'b1; i_data = 32'h0000_0001;
    tick();
    i_wr = 1'b0;
    check_eq("single_stb",  64'(o_stb), 64'd1);
    check_eq("single_data", 64'(o_data), 64'h1);
    check_eq("single_fill", 64'(o_fill), 64'd1);
    tick();
    check_eq("single_fill_after", 64'(o_fill), 64'd0);
    check_eq("single_stb_after",  64'(o_stb), 64'd0);

    // Burst of 16 while busy fills the FIFO
    i_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      i_wr = 1'b1; i_data = 32'h10 + 32'(i);
      tick();
    end
    i_wr = 1'b0;
    check_eq("burst_full", 64'(o_full), 64'd1);
    check_eq("burst_fill", 64'(o_fill), 64'd16);
    check_eq("burst_head", 64'(o_data), 64'h10);
    tick();
    check_eq("busy_hold_data", 64'(o_data), 64'h10);

    // Push and pop in the same cycle while full
    i_busy = 1'b0; i_wr = 1'b1; i_data = 32'hA5A5_A5A5;
    tick();
    i_wr = 1'b0; i_busy = 1'b1;
    check_eq("fullpp_fill", 64'(o_fill), 64'd16);
    check_eq("fullpp_ovf",  64'(o_overflow), 64'd0);
    check_eq("fullpp_head", 64'(o_data), 64'h11);

    // Write while full and busy is dropped
    i_wr = 1'b1; i_data = 32'hDEAD_BEEF;
    tick();
    i_wr = 1'b0;
    check_eq("ovf_set",  64'(o_overflow), 64'd1);
    check_eq("ovf_fill", 64'(o_fill), 64'd16);
    check_eq("ovf_head", 64'(o_data), 64'h11);
    tick();
    check_eq("ovf_sticky", 64'(o_overflow), 64'd1);

    // Drain: 0x11..0x1F then 0xA5A5A5A5 on consecutive cycles
    for (int i = 0; i < 15; i++) drain_exp[i] = 32'h11 + 32'(i);
    drain_exp[15] = 32'hA5A5_A5A5;
    i_busy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("drain_stb%0d", i), 64'(o_stb), 64'd1);
      check_eq($sformatf("drain_data%0d", i), 64'(o_data), 64'(drain_exp[i]));
      tick();
    end
    check_eq("drain_empty_stb",  64'(o_stb), 64'd0);
    check_eq("drain_empty_fill", 64'(o_fill), 64'd0);
    check_eq("drain_ovf_sticky", 64'(o_overflow), 64'd1);

    // Wrap-around: 40 words with random busy, checked against a queue
    sent = 0;
    cyc  = 0;
    while ((sent < 40 || exp_q.size() != 0) && cyc < 2000) begin
      i_busy = ($urandom_range(0, 2) == 0);
      if (o_stb && !i_busy) begin
        if (exp_q.size() == 0) begin
          check_eq("wrap_unexpected_stb", 64'(o_stb), 64'd0);
        end else begin
          head = exp_q.pop_front();
          check_eq("wrap_data", 64'(o_data), 64'(head));
        end
      end
      if (sent < 40 && !o_full && ($urandom_range(0, 3) != 0)) begin
        i_wr   = 1'b1;
        i_data = 32'h100 + 32'(sent);
        exp_q.push_back(i_data);
        sent++;
      end else begin
        i_wr = 1'b0;
      end
      tick();
      cyc++;
    end
    i_wr = 1'b0;
    check_eq("wrap_done", 64'(cyc < 2000), 64'd1);
    check_eq("wrap_fill", 64'(o_fill), 64'd0);

    // Async reset mid-drain
    i_busy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      i_wr = 1'b1; i_data = 32'h20 + 32'(i);
      tick();
    end
    i_wr = 1'b0; i_busy = 1'b0;
    tick();
    tick();
    i_busy = 1'b1;
    check_eq("pre_rst_fill", 64'(o_fill), 64'd5);
    #2;
    i_reset_n = 1'b0;
    #1;
    check_eq("arst_stb",  64'(o_stb), 64'd0);
    check_eq("arst_fill", 64'(o_fill), 64'd0);
    check_eq("arst_ovf",  64'(o_overflow), 64'd0);
    check_eq("arst_full", 64'(o_full), 64'd0);
    #2;
    i_reset_n = 1'b1;
    i_busy    = 1'b0;
    tick();
    i_wr = 1'b1; i_data = 32'h7;
    tick();
    i_wr = 1'b0;
    check_eq("post_rst_stb",  64'(o_stb), 64'd1);
    check_eq("post_rst_data", 64'(o_data), 64'h7);
    tick();
    check_eq("post_rst_fill", 64'(o_fill), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
